// File: rtl/spi_target_pkg.sv
// Shared types and frame-length constants for the SPI bus-access target.
package spi_target_pkg;

    typedef enum logic [1:0] {
        OP_WRITE_NEXT = 2'b00,
        OP_READ_NEXT  = 2'b01,
        OP_WRITE      = 2'b10,
        OP_READ       = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        DATA,
        DONE
    } frame_state_t;

    typedef enum logic {
        BUS_IDLE,
        BUS_REQ
    } bus_state_t;

    // Number of bytes, command byte included, that make up a complete frame.
    localparam logic [2:0] BYTES_WRITE      = 3'd4;
    localparam logic [2:0] BYTES_READ       = 3'd3;
    localparam logic [2:0] BYTES_WRITE_NEXT = 3'd2;
    localparam logic [2:0] BYTES_READ_NEXT  = 3'd1;

    function automatic logic [2:0] op_bytes(input op_t op);
        case (op)
            OP_WRITE:      op_bytes = BYTES_WRITE;
            OP_READ:       op_bytes = BYTES_READ;
            OP_WRITE_NEXT: op_bytes = BYTES_WRITE_NEXT;
            default:       op_bytes = BYTES_READ_NEXT;
        endcase
    endfunction

endpackage

// File: rtl/spi_target_sync_shift.sv
// Oversampling front end: synchronizes SCK, /CS and SDI into clk_sys,
// detects SCK edges and runs the receive/transmit shift registers.
module spi_sync_shift #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       sdi,
    input  logic [7:0] tx_load_byte,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       cs_active,
    output logic       sdo
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sck_prev;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift;
    logic [7:0]             tx_shift;
    logic                   sck_s;
    logic                   sdi_s;
    logic                   sck_rise;
    logic                   sck_fall;

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign cs_active = ~cs_sync[SYNC_STAGES-1];
    assign sck_rise  = cs_active & sck_s & ~sck_prev;
    assign sck_fall  = cs_active & ~sck_s & sck_prev;
    assign sdo       = cs_active ? tx_shift[7] : tx_load_byte[7];

    // Synchronizer chains; /CS resets to deselected so reset never opens a frame.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sdi_sync <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= (sck_sync << 1) | SYNC_STAGES'(sck);
            cs_sync  <= (cs_sync << 1) | SYNC_STAGES'(cs_n);
            sdi_sync <= (sdi_sync << 1) | SYNC_STAGES'(sdi);
            sck_prev <= sck_s;
        end
    end

    // Shift SDI in on SCK rise, SDO out on SCK fall; reload transmit data per byte.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            rx_byte    <= 8'h00;
            tx_shift   <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (!cs_active) begin
                bit_cnt  <= 3'd0;
                tx_shift <= tx_load_byte;
            end else begin
                if (sck_rise) begin
                    rx_shift <= {rx_shift[6:0], sdi_s};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_valid <= 1'b1;
                        rx_byte    <= {rx_shift[6:0], sdi_s};
                    end
                end
                if (sck_fall) begin
                    tx_shift <= (bit_cnt == 3'd0) ? tx_load_byte : {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target that decodes bus-access frames and issues single-beat
// read/write requests to the system bus arbiter.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                  clk_sys_i,
    input  logic                  reset_i,
    input  logic                  spi_sck_i,
    input  logic                  spi_cs_ni,
    input  logic                  spi_rx_i,
    output logic                  spi_tx_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [7:0]            bus_wr_data_o,
    output logic                  bus_we_o,
    output logic                  bus_req_o,
    input  logic                  bus_ack_i,
    input  logic [7:0]            bus_rd_data_i,
    output logic                  overrun_o
);

    frame_state_t          frame_state;
    frame_state_t          frame_next;
    bus_state_t            bus_state;
    bus_state_t            bus_next;
    op_t                   op_q;
    op_t                   cur_op;
    logic [1:0]            byte_idx;
    logic [7:0]            addr_hi_q;
    logic [7:0]            addr_lo_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [7:0]            rd_data_q;
    logic                  byte_valid;
    logic [7:0]            rx_byte;
    logic                  cs_active;
    logic                  in_frame;
    logic                  frame_done;
    logic                  cur_we;

    spi_sync_shift #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_shift (
        .clk_sys      (clk_sys_i),
        .reset        (reset_i),
        .sck          (spi_sck_i),
        .cs_n         (spi_cs_ni),
        .sdi          (spi_rx_i),
        .tx_load_byte (rd_data_q),
        .byte_valid   (byte_valid),
        .rx_byte      (rx_byte),
        .cs_active    (cs_active),
        .sdo          (spi_tx_o)
    );

    // The op is taken straight from the command byte while it is arriving.
    assign cur_op     = (frame_state == CMD) ? op_t'(rx_byte[7:6]) : op_q;
    assign cur_we     = (cur_op == OP_WRITE) || (cur_op == OP_WRITE_NEXT);
    assign in_frame   = frame_state inside {CMD, ADDR_HI, ADDR_LO, DATA};
    assign frame_done = byte_valid && cs_active && in_frame &&
                        (({1'b0, byte_idx} + 3'd1) == op_bytes(cur_op));

    // Target address of the frame that is completing this cycle.
    always_comb begin
        next_addr = addr_q + ADDR_WIDTH'(1);
        if (cur_op == OP_READ) begin
            next_addr = ADDR_WIDTH'({addr_hi_q, rx_byte});
        end else if (cur_op == OP_WRITE) begin
            next_addr = ADDR_WIDTH'({addr_hi_q, addr_lo_q});
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) frame_state <= IDLE;
        else         frame_state <= frame_next;
    end

    // Frame FSM: route each received byte by position; /CS release aborts.
    always_comb begin
        frame_next = frame_state;
        if (!cs_active) begin
            frame_next = IDLE;
        end else begin
            case (frame_state)
                IDLE:    frame_next = CMD;
                CMD: if (byte_valid) begin
                    if (cur_op == OP_WRITE || cur_op == OP_READ) frame_next = ADDR_HI;
                    else if (cur_op == OP_WRITE_NEXT)           frame_next = DATA;
                    else                                        frame_next = DONE;
                end
                ADDR_HI: if (byte_valid) frame_next = ADDR_LO;
                ADDR_LO: if (byte_valid) frame_next = (op_q == OP_WRITE) ? DATA : DONE;
                DATA:    if (byte_valid) frame_next = DONE;
                DONE:    frame_next = DONE;
                default: frame_next = IDLE;
            endcase
        end
    end

    // Capture command/address bytes and advance the auto-increment address.
    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            op_q      <= OP_WRITE_NEXT;
            byte_idx  <= 2'd0;
            addr_hi_q <= 8'h00;
            addr_lo_q <= 8'h00;
            addr_q    <= '0;
        end else begin
            if (!cs_active) begin
                byte_idx <= 2'd0;
            end else if (byte_valid && in_frame) begin
                byte_idx <= byte_idx + 2'd1;
            end
            if (byte_valid) begin
                case (frame_state)
                    CMD:     op_q      <= cur_op;
                    ADDR_HI: addr_hi_q <= rx_byte;
                    ADDR_LO: addr_lo_q <= rx_byte;
                    default: ;
                endcase
            end
            if (frame_done) addr_q <= next_addr;
        end
    end

    // Bus FSM state register.
    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) bus_state <= BUS_IDLE;
        else         bus_state <= bus_next;
    end

    // Bus FSM: an ack coinciding with a new frame hands straight over to it.
    always_comb begin
        bus_next = bus_state;
        case (bus_state)
            BUS_IDLE: if (frame_done) bus_next = BUS_REQ;
            BUS_REQ:  if (bus_ack_i && !frame_done) bus_next = BUS_IDLE;
            default:  bus_next = BUS_IDLE;
        endcase
    end

    // Registered request fields, read-data capture and sticky overrun flag.
    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            bus_addr_o    <= '0;
            bus_wr_data_o <= 8'h00;
            bus_we_o      <= 1'b0;
            bus_req_o     <= 1'b0;
            overrun_o     <= 1'b0;
            rd_data_q     <= 8'h00;
        end else begin
            bus_req_o <= (bus_next == BUS_REQ);
            if (frame_done && (bus_state == BUS_IDLE || bus_ack_i)) begin
                bus_addr_o    <= next_addr;
                bus_we_o      <= cur_we;
                bus_wr_data_o <= cur_we ? rx_byte : 8'h00;
            end
            if (frame_done && bus_state == BUS_REQ && !bus_ack_i) begin
                overrun_o <= 1'b1;
            end
            if (bus_state == BUS_REQ && bus_ack_i && !bus_we_o) begin
                rd_data_q <= bus_rd_data_i;
            end
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Directed self-checking bench for spi_target: drives SPI frames bit by bit
// and checks the resulting bus requests, SDO read-back and overrun flag.
module tb_spi_target;

    logic        clk;
    logic        reset;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_rx;
    logic        spi_tx;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wr_data;
    logic        bus_we;
    logic        bus_req;
    logic        bus_ack;
    logic [7:0]  bus_rd_data;
    logic        overrun;

    int          vectors;
    int          miscompares;
    time         last_rise_time;
    time         req_rise_time;
    bit          ack_on_last;
    logic [7:0]  ack_rd;
    logic [7:0]  rx0;

    spi_target #(
        .SYNC_STAGES (2),
        .ADDR_WIDTH  (16)
    ) dut (
        .clk_sys_i     (clk),
        .reset_i       (reset),
        .spi_sck_i     (spi_sck),
        .spi_cs_ni     (spi_cs_n),
        .spi_rx_i      (spi_rx),
        .spi_tx_o      (spi_tx),
        .bus_addr_o    (bus_addr),
        .bus_wr_data_o (bus_wr_data),
        .bus_we_o      (bus_we),
        .bus_req_o     (bus_req),
        .bus_ack_i     (bus_ack),
        .bus_rd_data_i (bus_rd_data),
        .overrun_o     (overrun)
    );

    // System clock, period 10; inputs change on falling edges only.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Timestamp every request rising edge for the latency check.
    always @(posedge bus_req) req_rise_time = $time;

    // Hard stop if the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One SPI byte, MSB first, SCK period 80; optional ack lands in the completion cycle.
    task automatic spiByte(input logic [7:0] tx, output logic [7:0] rx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spi_rx = tx[i];
            #40;
            spi_sck = 1'b1;
            r[i] = spi_tx;
            last_rise_time = $time;
            if (i == 0 && ack_on_last) begin
                #30;
                bus_ack = 1'b1;
                bus_rd_data = ack_rd;
                #10;
                bus_ack = 1'b0;
                bus_rd_data = 8'h00;
            end else begin
                #40;
            end
            spi_sck = 1'b0;
        end
        rx = r;
    endtask

    // Full /CS-framed transfer of nbytes; returns the SDO byte seen during byte 0.
    task automatic applyStimulus(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3, output logic [7:0] first_rx);
        logic [7:0] frame [4];
        logic [7:0] r;
        frame = '{b0, b1, b2, b3};
        first_rx = 8'h00;
        spi_cs_n = 1'b0;
        #40;
        for (int k = 0; k < nbytes; k++) begin
            spiByte(frame[k], r);
            if (k == 0) first_rx = r;
        end
        #40;
        spi_cs_n = 1'b1;
        #80;
    endtask

    task automatic waitReq();
        for (int i = 0; i < 200; i++) begin
            if (bus_req) break;
            @(negedge clk);
        end
        checkOutput("req_seen", 32'(bus_req), 32'd1);
    endtask

    task automatic ackBus(input logic [7:0] rd);
        @(negedge clk);
        bus_ack = 1'b1;
        bus_rd_data = rd;
        checkOutput("req_at_ack", 32'(bus_req), 32'd1);
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rd_data = 8'h00;
        checkOutput("req_drop", 32'(bus_req), 32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        ack_on_last = 1'b0;
        ack_rd = 8'h00;
        last_rise_time = 0;
        req_rise_time = 0;
        reset = 1'b1;
        spi_sck = 1'b0;
        spi_cs_n = 1'b1;
        spi_rx = 1'b0;
        bus_ack = 1'b0;
        bus_rd_data = 8'h00;
        #20;
        reset = 1'b0;
        #40;

        $display("[TB] reset state");
        checkOutput("rst_req", 32'(bus_req), 32'd0);
        checkOutput("rst_addr", 32'(bus_addr), 32'd0);
        checkOutput("rst_wdata", 32'(bus_wr_data), 32'd0);
        checkOutput("rst_we", 32'(bus_we), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_tx", 32'(spi_tx), 32'd0);

        $display("[TB] reset while request and frame are active");
        applyStimulus(4, 8'h80, 8'h12, 8'h34, 8'hA5, rx0);
        waitReq();
        spi_cs_n = 1'b0;
        #40;
        spiByte(8'h80, rx0);
        reset = 1'b1;
        #1;
        checkOutput("midrst_req", 32'(bus_req), 32'd0);
        checkOutput("midrst_addr", 32'(bus_addr), 32'd0);
        checkOutput("midrst_wdata", 32'(bus_wr_data), 32'd0);
        checkOutput("midrst_we", 32'(bus_we), 32'd0);
        #9;
        spi_cs_n = 1'b1;
        #20;
        reset = 1'b0;
        #40;

        $display("[TB] WRITE 0x1234 <= 0xA5");
        applyStimulus(4, 8'h80, 8'h12, 8'h34, 8'hA5, rx0);
        waitReq();
        checkOutput("wr_latency", 32'(req_rise_time - last_rise_time), 32'd35);
        checkOutput("wr_addr", 32'(bus_addr), 32'h1234);
        checkOutput("wr_we", 32'(bus_we), 32'd1);
        checkOutput("wr_data", 32'(bus_wr_data), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("wr_hold_req", 32'(bus_req), 32'd1);
            checkOutput("wr_hold_addr", 32'(bus_addr), 32'h1234);
        end
        ackBus(8'h00);

        $display("[TB] READ 0x8000 then READ_NEXT");
        applyStimulus(3, 8'hC0, 8'h80, 8'h00, 8'h00, rx0);
        waitReq();
        checkOutput("rd_addr", 32'(bus_addr), 32'h8000);
        checkOutput("rd_we", 32'(bus_we), 32'd0);
        ackBus(8'h5A);
        #40;
        applyStimulus(1, 8'h40, 8'h00, 8'h00, 8'h00, rx0);
        checkOutput("rdn_sdo", 32'(rx0), 32'h5A);
        waitReq();
        checkOutput("rdn_addr", 32'(bus_addr), 32'h8001);
        checkOutput("rdn_we", 32'(bus_we), 32'd0);
        ackBus(8'h3C);

        $display("[TB] address wrap 0xFFFF -> 0x0000");
        applyStimulus(4, 8'h80, 8'hFF, 8'hFF, 8'h11, rx0);
        waitReq();
        checkOutput("wrff_addr", 32'(bus_addr), 32'hFFFF);
        ackBus(8'h00);
        applyStimulus(2, 8'h00, 8'h77, 8'h00, 8'h00, rx0);
        waitReq();
        checkOutput("wrap_addr", 32'(bus_addr), 32'h0000);
        checkOutput("wrap_data", 32'(bus_wr_data), 32'h77);
        checkOutput("wrap_we", 32'(bus_we), 32'd1);
        ackBus(8'h00);

        $display("[TB] aborted WRITE frame");
        applyStimulus(2, 8'h80, 8'h55, 8'h00, 8'h00, rx0);
        #100;
        checkOutput("abort_noreq", 32'(bus_req), 32'd0);
        applyStimulus(2, 8'h00, 8'h99, 8'h00, 8'h00, rx0);
        waitReq();
        checkOutput("abort_next_addr", 32'(bus_addr), 32'h0001);
        checkOutput("abort_next_data", 32'(bus_wr_data), 32'h99);
        ackBus(8'h00);

        $display("[TB] ack while idle is ignored");
        @(negedge clk);
        bus_ack = 1'b1;
        bus_rd_data = 8'hFF;
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rd_data = 8'h00;
        @(negedge clk);
        checkOutput("idle_ack_req", 32'(bus_req), 32'd0);
        checkOutput("idle_ack_tx", 32'(spi_tx), 32'd0);

        $display("[TB] ack coinciding with frame completion");
        applyStimulus(1, 8'h40, 8'h00, 8'h00, 8'h00, rx0);
        waitReq();
        checkOutput("hold_addr", 32'(bus_addr), 32'h0002);
        ack_on_last = 1'b1;
        ack_rd = 8'hE7;
        applyStimulus(1, 8'h40, 8'h00, 8'h00, 8'h00, rx0);
        ack_on_last = 1'b0;
        checkOutput("same_cycle_overrun", 32'(overrun), 32'd0);
        checkOutput("same_cycle_req", 32'(bus_req), 32'd1);
        checkOutput("same_cycle_addr", 32'(bus_addr), 32'h0003);
        checkOutput("same_cycle_rdback", 32'(spi_tx), 32'd1);

        $display("[TB] overrun with ack withheld");
        applyStimulus(1, 8'h40, 8'h00, 8'h00, 8'h00, rx0);
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        checkOutput("ovr_req", 32'(bus_req), 32'd1);
        checkOutput("ovr_addr", 32'(bus_addr), 32'h0003);
        checkOutput("ovr_we", 32'(bus_we), 32'd0);
        ackBus(8'h00);
        #40;
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
FPGA-side SPI target (mode 0, MSB first) that decodes bus-access commands from the MCU SPI controller. It issues single-beat read/write requests to the system bus arbiter, all in the clk_sys domain. SCK, /CS and SDI are oversampled through synchronizers; no logic is clocked by SCK. Read results are returned on SDO during the command byte of the following transaction.

Parameters:
SYNC_STAGES, 2, synchronizer depth for spi_sck_i / spi_cs_ni / spi_rx_i
ADDR_WIDTH, 16, bus address width

Ports:
clk_sys_i  input  1  system clock; must be >= 4x SCK frequency
reset_i  input  1  asynchronous, active-high reset
spi_sck_i  input  1  SPI clock from controller, CPOL=0
spi_cs_ni  input  1  SPI chip select, active low
spi_rx_i  input  1  controller-to-target data (SDI)
spi_tx_o  output  1  target-to-controller data (SDO)
bus_addr_o  output  ADDR_WIDTH  request address
bus_wr_data_o  output  8  write data
bus_we_o  output  1  1 = write, 0 = read; valid while bus_req_o is high
bus_req_o  output  1  request pending
bus_ack_i  input  1  one-cycle completion strobe from arbiter
bus_rd_data_i  input  8  read data; valid when bus_ack_i is high
overrun_o  output  1  sticky: a frame completed while a request was pending

Behaviour:
- Reset (async) value of every output is 0. Internal addr_q = 0, rd_data_q = 8'h00, frame FSM = IDLE, bus FSM = BUS_IDLE. Reset mid-frame or mid-request drops bus_req_o immediately, and the partial frame is discarded.
- Sampling: synchronized SCK rising edge shifts SDI into rx_shift. Synchronized SCK falling edge shifts tx_shift out on SDO. A 3-bit counter advances per rising edge. Byte complete = 8th rising edge.
- While /CS is high (synced): bit counter = 0, tx_shift = rd_data_q, and spi_tx_o = rd_data_q[7]. The MSB is therefore valid before the first SCK rise. tx_shift reloads with rd_data_q on every byte boundary.
- Command byte, bits[7:6] = op, bits[5:0] reserved and ignored:
  - 2'b10 WRITE: cmd, addr_hi, addr_lo, data
  - 2'b11 READ: cmd, addr_hi, addr_lo
  - 2'b00 WRITE_NEXT: cmd, data; uses addr_q+1
  - 2'b01 READ_NEXT: cmd; uses addr_q+1
- Frame FSM states and transitions:
  - IDLE -> CMD on /CS fall.
  - CMD -> ADDR_HI (op[1]=1), DATA (WRITE_NEXT), or DONE (READ_NEXT).
  - ADDR_HI -> ADDR_LO -> DATA (write) or DONE (read).
  - DATA -> DONE.
  - DONE ignores further bytes.
  - Any state -> IDLE on /CS rise.
- Frame completion occurs on the clk_sys cycle that completes the last required byte. On that cycle, addr_q is updated: the loaded address, or addr_q+1 mod 2^ADDR_WIDTH. 16'hFFFF wraps to 16'h0000.
- /CS rise before completion: no request, addr_q unchanged, no error.
- Bus FSM: BUS_IDLE -> BUS_REQ on frame completion. bus_req_o, bus_addr_o, bus_we_o and bus_wr_data_o are registered, valid the next clk_sys cycle, and held stable until bus_ack_i. Latency from the final SCK rise to bus_req_o = SYNC_STAGES + 2 clk_sys cycles.
- BUS_REQ -> BUS_IDLE on bus_ack_i; bus_req_o deasserts the following cycle. On a read, rd_data_q <= bus_rd_data_i at the ack cycle.
- bus_ack_i while in BUS_IDLE is ignored.
- Frame completion while in BUS_REQ: that frame is dropped, overrun_o <= 1 (sticky until reset), and the pending request is undisturbed.
- Frame completion and bus_ack_i in the same cycle: the ack retires the old request and the new request is accepted (not an overrun).

Decomposition:
- Package spi_target_pkg:
  - op_t enum (OP_WRITE_NEXT=2'b00, OP_READ_NEXT=2'b01, OP_WRITE=2'b10, OP_READ=2'b11)
  - frame_state_t and bus_state_t enums
  - localparam byte-count per op
- One sub-module, spi_sync_shift: synchronizers, edge detect, rx/tx shift registers and bit counter. Outputs byte_valid, rx_byte and cs_active; input tx_load_byte. The top module holds both FSMs and the address register.

Test Plan:
- Reset while a frame and bus_req_o are active: all outputs 0 immediately; the next frame decodes normally.
- WRITE 8'h80,8'h12,8'h34,8'hA5: bus_req_o=1 with addr 16'h1234, we=1, data 8'hA5. It holds for 5 cycles until ack, then drops one cycle after ack.
- READ 8'hC0,8'h80,8'h00, ack with rd_data 8'h5A; next transaction READ_NEXT 8'h40: SDO during byte 0 = 8'h5A. The request addr is 16'h8001 with we=0.
- WRITE to 16'hFFFF, then WRITE_NEXT 8'h00,8'h77: request addr 16'h0000, data 8'h77.
- /CS raised after 2 bytes of WRITE: no bus_req_o; a following WRITE_NEXT targets old addr_q+1.
- Two READ_NEXT frames with bus_ack_i withheld: first request held unchanged, overrun_o=1. Ack in the same cycle as a completion: no overrun, second request issued.
